float_pack_seq: RTL and testbench
=================================

FLOAT_PACK_SEQ -- requirements
Module: float_pack_seq

Interface
REQ-001 SHALL have ports: clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have in_valid, input, 1, operand present.
REQ-004 SHALL have in_ready, output, 1, block can accept an operand.
REQ-005 SHALL have S_in, input, 1, sign.
REQ-006 SHALL have E_in, input, 10, two's-complement unbiased exponent.
REQ-007 SHALL have M_in, input, 32, unsigned fixed-point magnitude, 2 integer bits and 30 fraction bits; value = (-1)^S_in x M_in/2^30 x 2^E_in.
REQ-008 SHALL have out_valid, output, 1, result present.
REQ-009 SHALL have out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have P, output, 32, IEEE-754 single-precision result {S, E[7:0], M[22:0]}.
REQ-011 SHALL have ovf, output, 1, result saturated to infinity.
REQ-012 SHALL have unf, output, 1, result flushed to zero.

Function
REQ-013 SHALL use FSM states IDLE, NORM, ROUND, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 IDLE: on in_valid & in_ready, SHALL capture S_in, E_in (sign-extended to 11-bit internal exponent), M_in, clear sticky, go to NORM; otherwise stay in IDLE.
REQ-015 NORM, one action per cycle, first match wins: M==0 -> ROUND; M[31]==1 -> M>>1, E+1, sticky |= shifted-out bit; M[30]==0 -> M<<1, E-1; else (M[31:30]==01) -> ROUND.
REQ-016 Latency from accepting edge to out_valid high SHALL be k+2 cycles, k = number of shifts (0..30); zero operand gives latency 2.
REQ-017 ROUND SHALL use fraction = M[29:7], guard = M[6], sticky = |M[5:0] | sticky register; round-to-nearest-even: increment when guard & (sticky | M[7]).
REQ-018 A fraction increment carrying out of 23 bits SHALL yield fraction 0 and E+1.
REQ-019 Biased exponent = E+127, computed without wrap in at least 11 bits signed.
REQ-020 Biased >= 255 SHALL give P = {S, 8'hFF, 23'h0} with ovf=1.
REQ-021 Biased <= 0 (no subnormals) or M==0 SHALL give P = {S, 31'h0}; unf=1 only for nonzero M.
REQ-022 Otherwise SHALL give P = {S, biased[7:0], fraction} with ovf=unf=0; ROUND registers P/ovf/unf and goes to DONE.
REQ-023 DONE: P, ovf, unf SHALL be held stable while out_valid & !out_ready; on out_ready -> IDLE. No operand is accepted in the cycle the result is consumed; in_ready rises the following cycle.
REQ-024 P, ovf, unf SHALL keep their last values in IDLE, NORM and ROUND; in_valid and input data are ignored outside IDLE.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE and clear P=32'h0, ovf=0, unf=0, sticky=0 and internal M/E; out_valid=0, in_ready=1 after that edge.
REQ-026 rst SHALL override all other activity in any state, including mid-NORM; the in-flight operand is discarded and produces no output.

Verification
REQ-027 S=0,E=0,M=0x40000000 -> P=0x3F800000, ovf=unf=0, out_valid 2 cycles after accept.
REQ-028 M=0x80000000,E=0 -> P=0x40000000 (latency 3); M=0x20000000,E=0 -> P=0x3F000000 (latency 3); M=0x00000001,E=0 -> P=0x30800000 (latency 32).
REQ-029 Rounding: M=0x40000040 -> 0x3F800000 (tie, even down); M=0x400000C0 -> 0x3F800002 (tie, odd up); M=0x7FFFFFC0 -> 0x40000000 (carry into exponent).
REQ-030 Limits: E=200,M=0x40000000 -> P=0x7F800000, ovf=1; S=1,E=-127,M=0x40000000 -> P=0x80000000, unf=1; S=1,M=0 -> P=0x80000000, unf=0.
REQ-031 Backpressure and reset: out_ready low 5 cycles -> P stable, in_ready=0 throughout; rst asserted during NORM -> IDLE next cycle, out_valid never rises, a following operand processes correctly.

Source files
------------

// File: rtl/float_pack_seq.sv
// float_pack_seq: sequential packer from an unnormalized sign/exponent/
// fixed-point magnitude triple to IEEE-754 single precision.
// Normalization uses one shift per cycle. Rounding is round-to-nearest-even.
// Overflow saturates to infinity. Underflow flushes to signed zero, because
// subnormals are not produced.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand handshake (S_in, E_in, M_in)
//   out_valid / out_ready    result handshake (P, ovf, unf)
module float_pack_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S_in,
  input  logic [9:0]  E_in,
  input  logic [31:0] M_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] P,
  output logic        ovf,
  output logic        unf
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic               s_q, s_d;
  logic signed [10:0] e_q, e_d;
  logic [31:0]        m_q, m_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        p_q, p_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  // Rounding datapath. It is only meaningful while in ROUND.
  logic [22:0]        frac;
  logic               guard, st, inc;
  logic [23:0]        frac_inc;
  logic signed [12:0] biased;

  always_comb begin
    frac     = m_q[29:7];
    guard    = m_q[6];
    st       = (|m_q[5:0]) | sticky_q;
    inc      = guard & (st | m_q[7]);
    frac_inc = {1'b0, frac} + {23'h0, inc};
    // Widen to 13 bits so that large exponents cannot wrap past the bias.
    // A carry out of the fraction bumps the exponent.
    biased   = {{2{e_q[10]}}, e_q} + 13'sd127 + {12'h0, frac_inc[23]};
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    e_d      = e_q;
    m_d      = m_q;
    sticky_d = sticky_q;
    p_d      = p_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        s_d      = S_in;
        e_d      = {E_in[9], E_in};
        m_d      = M_in;
        sticky_d = 1'b0;
        state_d  = NORM;
      end
      NORM: begin
        if (m_q == 32'h0) begin
          state_d = ROUND;
        end else if (m_q[31]) begin
          m_d      = {1'b0, m_q[31:1]};
          e_d      = e_q + 11'sd1;
          sticky_d = sticky_q | m_q[0];
        end else if (!m_q[30]) begin
          m_d = {m_q[30:0], 1'b0};
          e_d = e_q - 11'sd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (m_q == 32'h0) begin
          p_d = {s_q, 31'h0};
        end else if (biased >= 13'sd255) begin
          p_d   = {s_q, 8'hFF, 23'h0};
          ovf_d = 1'b1;
        end else if (biased <= 13'sd0) begin
          p_d   = {s_q, 31'h0};
          unf_d = 1'b1;
        end else begin
          // On a carry out of the fraction, frac_inc[22:0] is already zero.
          p_d = {s_q, biased[7:0], frac_inc[22:0]};
        end
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      e_q      <= '0;
      m_q      <= '0;
      sticky_q <= 1'b0;
      p_q      <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      e_q      <= e_d;
      m_q      <= m_d;
      sticky_q <= sticky_d;
      p_q      <= p_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign P         = p_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
endmodule

// File: tb/tb_float_pack_seq.sv
// Self-checking bench for float_pack_seq. It uses directed corner vectors
// plus randomized operands, checked against a value-level reference model.
module tb_float_pack_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        S_in = 1'b0;
  logic [9:0]  E_in = '0;
  logic [31:0] M_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] P;
  logic        ovf, unf;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_p;
  logic        prev_ovf, prev_unf;

  float_pack_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .S_in(S_in), .E_in(E_in), .M_in(M_in), .out_valid(out_valid),
    .out_ready(out_ready), .P(P), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. It locates the leading one of the magnitude. It then
  // takes the 23 bits below it as the fraction, the next bit as guard, and
  // everything lower as sticky. Then it rounds to nearest even and applies the
  // exponent limits.
  function automatic void model(input logic s, input logic signed [9:0] e,
                                input logic [31:0] m, output logic [31:0] p,
                                output logic ov, output logic un, output int lat);
    int pos, ee, bi, sh;
    logic [63:0] v;
    logic [23:0] fi;
    logic g, st;
    ov = 1'b0; un = 1'b0;
    if (m == 32'h0) begin
      p = {s, 31'h0}; lat = 2; return;
    end
    pos = 31;
    while (!m[pos]) pos--;
    ee  = int'(e) + pos - 30;
    lat = ((pos >= 30) ? pos - 30 : 30 - pos) + 2;
    v   = {m, 32'h0};
    sh  = pos + 32 - 24;
    g   = v[sh];
    st  = (v & ((64'd1 << sh) - 64'd1)) != 64'd0;
    fi  = {1'b0, 23'(v >> (sh + 1))};
    if (g && (st || fi[0])) fi = fi + 24'd1;
    if (fi[23]) begin fi = '0; ee++; end
    bi = ee + 127;
    if (bi >= 255)     begin p = {s, 8'hFF, 23'h0}; ov = 1'b1; end
    else if (bi <= 0)  begin p = {s, 31'h0};        un = 1'b1; end
    else               p = {s, 8'(bi), fi[22:0]};
  endfunction

  task automatic run_op(input logic s, input logic [9:0] e, input logic [31:0] m, input int hold);
    logic [31:0] ep; logic eo, eu; int el, lat;
    logic [31:0] held;
    model(s, e, m, ep, eo, eu, el);
    @(negedge clk);
    S_in = s; E_in = e; M_in = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    S_in = ~s; E_in = ~e; M_in = ~m;  // inputs must not matter after capture
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("p_held_busy", {P, ovf, unf}, {prev_p, prev_ovf, prev_unf});
      chk("in_ready_busy", in_ready, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, el);
    chk("P", P, ep);
    chk("ovf", ovf, eo);
    chk("unf", unf, eu);
    held = P;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_P", P, held);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("consume_out_valid", out_valid, 1'b0);
    chk("consume_in_ready", in_ready, 1'b1);
    prev_p = ep; prev_ovf = eo; prev_unf = eu;
  endtask

  initial begin
    logic [31:0] m;
    logic [9:0]  e;
    int seen;
    prev_p = '0; prev_ovf = 1'b0; prev_unf = 1'b0;
    @(posedge clk); #1;
    chk("rst_P", P, 32'h0);
    chk("rst_flags", {ovf, unf}, 2'b00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk); rst = 1'b0;

    // Directed corner vectors.
    run_op(1'b0, 10'd0, 32'h4000_0000, 0);
    run_op(1'b0, 10'd0, 32'h8000_0000, 0);
    run_op(1'b0, 10'd0, 32'h2000_0000, 0);
    run_op(1'b0, 10'd0, 32'h0000_0001, 0);
    run_op(1'b0, 10'd0, 32'h4000_0040, 0);
    run_op(1'b0, 10'd0, 32'h4000_00C0, 0);
    run_op(1'b0, 10'd0, 32'h7FFF_FFC0, 0);
    run_op(1'b0, 10'd200, 32'h4000_0000, 0);
    run_op(1'b1, -10'sd127, 32'h4000_0000, 0);
    run_op(1'b1, 10'd0, 32'h0000_0000, 0);
    run_op(1'b0, 10'd5, 32'hC000_0001, 5);  // backpressure plus sticky from shift-out

    // Reset while in NORM: the operand is discarded and no result appears.
    @(negedge clk);
    M_in = 32'h0000_0001; E_in = '0; S_in = 1'b0; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_P", P, 32'h0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("midrst_no_output", seen, 0);
    prev_p = '0; prev_ovf = 1'b0; prev_unf = 1'b0;
    run_op(1'b1, 10'd3, 32'h0123_4567, 1);

    // Randomized operands.
    for (int i = 0; i < 60; i++) begin
      m = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) m = '0;
      if ($urandom_range(0, 1) == 0) e = 10'($urandom_range(0, 280)) - 10'd140;
      else                           e = 10'($urandom);
      run_op(1'($urandom), e, m, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
